serial_master_port: RTL

- Upstream neighbour of the serial slave port: converts a parallel request from a local bus master into the serial address/data frame the slave consumes.
- Collects serial read data back on rd_bus and returns a parallel response with an error flag on timeout.
- One instance per bus master; the serial pins connect directly to a slave port.

---
 rtl/bus_pkg.sv | 16 +
 rtl/serial_shift_reg.sv | 31 +++
 rtl/serial_master_port.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the serial master/slave bus: frame mode encodings and
// the master port state machine encoding.
package bus_pkg;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_RD_WAIT,
    ST_RX,
    ST_RESP
  } master_state_e;

endpackage

// File: rtl/serial_shift_reg.sv
// Left-shifting register with parallel load, serial input and MSB tap.
// Load takes priority over shift.
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             serial_i,
  output logic [WIDTH-1:0] data_o,
  output logic             msb_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= load_data_i;
    end else if (shift_i) begin
      data_q <= (data_q << 1) | WIDTH'(serial_i);
    end
  end

  assign data_o = data_q;
  assign msb_o  = data_q[WIDTH-1];

endmodule

// File: rtl/serial_master_port.sv
// Serial bus master: serialises a parallel read/write request into an
// address+data frame and collects the serial read response, with a read timeout.
import bus_pkg::*;

module serial_master_port #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_mode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mode,
  output logic                  wr_bus,
  output logic                  master_valid,
  output logic                  master_ready,
  input  logic                  rd_bus,
  input  logic                  slave_ready,
  input  logic                  slave_valid,
  output master_state_e         dbg_state
);

  localparam int FW = ADDR_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(FW + 1);
  localparam int RW = $clog2(DATA_WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(FW - 1);
  localparam logic [RW-1:0] LAST_RX   = RW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

  master_state_e   state_q;
  logic [CW-1:0]   bit_cnt_q;
  logic [RW-1:0]   rx_cnt_q;
  logic [TW-1:0]   timer_q;
  logic            mode_lat_q;
  logic            err_q;
  logic            req_ready_q;
  logic            master_valid_q;
  logic            master_ready_q;
  logic            mode_q;
  logic            resp_valid_q;

  logic            tx_load;
  logic            tx_shift;
  logic            rx_shift;
  logic            tx_msb;
  logic [FW-1:0]   tx_par_unused;
  logic [DATA_WIDTH-1:0] rx_data;
  logic            rx_msb_unused;

  assign tx_load  = (state_q == ST_IDLE) && req_valid;
  assign tx_shift = (state_q == ST_TX) && slave_ready;
  assign rx_shift = ((state_q == ST_RD_WAIT) || (state_q == ST_RX)) && slave_valid;

  serial_shift_reg #(.WIDTH(FW)) u_tx (
    .clk         (clk),
    .resetn      (resetn),
    .load_i      (tx_load),
    .load_data_i ({req_addr, (req_mode == MODE_WRITE) ? req_wdata : {DATA_WIDTH{1'b0}}}),
    .shift_i     (tx_shift),
    .serial_i    (1'b0),
    .data_o      (tx_par_unused),
    .msb_o       (tx_msb)
  );

  // RX register is cleared at request accept so writes always report zero.
  serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_rx (
    .clk         (clk),
    .resetn      (resetn),
    .load_i      (tx_load),
    .load_data_i ({DATA_WIDTH{1'b0}}),
    .shift_i     (rx_shift),
    .serial_i    (rd_bus),
    .data_o      (rx_data),
    .msb_o       (rx_msb_unused)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= '0;
      rx_cnt_q       <= '0;
      timer_q        <= '0;
      mode_lat_q     <= MODE_READ;
      err_q          <= 1'b0;
      req_ready_q    <= 1'b1;
      master_valid_q <= 1'b0;
      master_ready_q <= 1'b0;
      mode_q         <= 1'b0;
      resp_valid_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            state_q        <= ST_TX;
            mode_lat_q     <= req_mode;
            mode_q         <= req_mode;
            bit_cnt_q      <= '0;
            err_q          <= 1'b0;
            req_ready_q    <= 1'b0;
            master_valid_q <= 1'b1;
          end
        end
        ST_TX: begin
          if (slave_ready) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              master_valid_q <= 1'b0;
              if (mode_lat_q == MODE_WRITE) begin
                state_q      <= ST_RESP;
                mode_q       <= 1'b0;
                resp_valid_q <= 1'b1;
              end else begin
                state_q        <= ST_RD_WAIT;
                master_ready_q <= 1'b1;
                timer_q        <= '0;
              end
            end
          end
        end
        ST_RD_WAIT, ST_RX: begin
          // A data bit beats the timeout; the timer only advances on idle cycles.
          if (slave_valid) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
            if (rx_cnt_q == LAST_RX) begin
              state_q        <= ST_RESP;
              master_ready_q <= 1'b0;
              mode_q         <= 1'b0;
              resp_valid_q   <= 1'b1;
            end else begin
              state_q <= ST_RX;
            end
          end else if (timer_q == LAST_TICK) begin
            state_q        <= ST_RESP;
            err_q          <= 1'b1;
            master_ready_q <= 1'b0;
            mode_q         <= 1'b0;
            resp_valid_q   <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          bit_cnt_q   <= '0;
          rx_cnt_q    <= '0;
          timer_q     <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign master_valid = master_valid_q;
  assign master_ready = master_ready_q;
  assign mode         = mode_q;
  assign wr_bus       = master_valid_q & tx_msb;
  assign resp_valid   = resp_valid_q;
  assign resp_err     = resp_valid_q & err_q;
  assign resp_rdata   = (resp_valid_q && !err_q && (mode_lat_q == MODE_READ)) ? rx_data
                                                                               : '0;
  assign dbg_state    = state_q;

endmodule
